// File: rtl/rca16_arb_pkg.sv
// rtl/rca16_arb_pkg.sv - shared constants and types for the rca16 adder arbiter
package rca16_arb_pkg;

  localparam int N_REQ  = 2;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The round-robin pointer only matters when both requesters ask at once.
  function automatic logic pick_winner(input logic r0, input logic r1, input logic rr_ptr);
    return (r0 & r1) ? rr_ptr : r1;
  endfunction

endpackage

// File: rtl/rca16_arbiter_if.sv
// rtl/rca16_arbiter_if.sv - requester/arbiter bus for the shared 16-bit adder
interface rca16_arbiter_if;
  import rca16_arb_pkg::*;

  logic              req0;
  logic [DATA_W-1:0] a0;
  logic [DATA_W-1:0] b0;
  logic              cin0;
  logic              req1;
  logic [DATA_W-1:0] a1;
  logic [DATA_W-1:0] b1;
  logic              cin1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] S;
  logic              cout;
  logic              busy;

  modport master (
    output req0, a0, b0, cin0, req1, a1, b1, cin1,
    input  ack0, ack1, S, cout, busy
  );

  modport slave (
    input  req0, a0, b0, cin0, req1, a1, b1, cin1,
    output ack0, ack1, S, cout, busy
  );

endinterface

// File: rtl/Ripple_Carry_Addr_16bit.sv
// rtl/Ripple_Carry_Addr_16bit.sv - 16-bit ripple-carry adder built from full-adder cells
module Ripple_Carry_Addr_16bit (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        cin,
  output logic [15:0] S,
  output logic        cout
);

  logic [16:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < 16; i++) begin : g_fa
    assign S[i]       = A[i] ^ B[i] ^ carry[i];
    assign carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
  end

  assign cout = carry[16];

endmodule

// File: rtl/rca16_arbiter.sv
// rtl/rca16_arbiter.sv - time-shares one ripple-carry adder between two requesters
module rca16_arbiter
  import rca16_arb_pkg::*;
#(
  parameter int PRIO_INIT = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  rca16_arbiter_if.slave bus
);

  localparam logic PRIO_BIT = 1'(PRIO_INIT);

  state_t            state;
  logic              grant;
  logic              rr_ptr;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              op_cin;
  logic [DATA_W-1:0] add_s;
  logic              add_cout;
  logic              winner;

  assign winner = pick_winner(bus.req0, bus.req1, rr_ptr);

  // Adder sees only the latched operands, never the live requester buses.
  Ripple_Carry_Addr_16bit u_adder (
    .A    (op_a),
    .B    (op_b),
    .cin  (op_cin),
    .S    (add_s),
    .cout (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= 1'b0;
      rr_ptr   <= PRIO_BIT;
      op_a     <= '0;
      op_b     <= '0;
      op_cin   <= 1'b0;
      bus.S    <= '0;
      bus.cout <= 1'b0;
      bus.ack0 <= 1'b0;
      bus.ack1 <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.ack0 <= 1'b0;
          bus.ack1 <= 1'b0;
          if (bus.req0 | bus.req1) begin
            state    <= ADD;
            bus.busy <= 1'b1;
            grant    <= winner;
            op_a     <= winner ? bus.a1   : bus.a0;
            op_b     <= winner ? bus.b1   : bus.b0;
            op_cin   <= winner ? bus.cin1 : bus.cin0;
          end
        end
        ADD: begin
          state    <= DONE;
          bus.busy <= 1'b1;
          bus.S    <= add_s;
          bus.cout <= add_cout;
          bus.ack0 <= ~grant;
          bus.ack1 <= grant;
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.ack0 <= 1'b0;
          bus.ack1 <= 1'b0;
          rr_ptr   <= ~grant;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.ack0 <= 1'b0;
          bus.ack1 <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rca16_arbiter.sv
// tb/tb_rca16_arbiter.sv - directed-vector bench for rca16_arbiter
module tb_rca16_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   idx;
  int   cyc;
  int   exp_idx;

  always #5 clk = ~clk;

  rca16_arbiter_if bus ();

  rca16_arbiter #(.PRIO_INIT(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // idx: 0/1 = which ack, 2 = both (illegal), -1 = none within budget.
  task automatic wait_ack(input int budget, output int who, output int cycles);
    bit seen;
    who    = -1;
    cycles = 0;
    seen   = 1'b0;
    for (int i = 1; i <= budget && !seen; i++) begin
      tick();
      if (bus.ack0 | bus.ack1) begin
        seen   = 1'b1;
        cycles = i;
        who    = (bus.ack0 & bus.ack1) ? 2 : (bus.ack1 ? 1 : 0);
      end
    end
  endtask

  task automatic clear_reqs;
    bus.req0 = 1'b0; bus.a0 = '0; bus.b0 = '0; bus.cin0 = 1'b0;
    bus.req1 = 1'b0; bus.a1 = '0; bus.b1 = '0; bus.cin1 = 1'b0;
  endtask

  task automatic do_reset;
    clear_reqs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    clear_reqs();
    tick();
    check("reset_S",    32'(bus.S),    0);
    check("reset_cout", 32'(bus.cout), 0);
    check("reset_ack0", 32'(bus.ack0), 0);
    check("reset_ack1", 32'(bus.ack1), 0);
    check("reset_busy", 32'(bus.busy), 0);
    rst_n = 1'b1;
    tick();

    // req0 alone
    bus.req0 = 1'b1; bus.a0 = 16'd414; bus.b0 = 16'd1036; bus.cin0 = 1'b0;
    tick();
    check("r0_busy_add", 32'(bus.busy), 1);
    check("r0_ack_early", 32'(bus.ack0), 0);
    tick();
    check("r0_ack0", 32'(bus.ack0), 1);
    check("r0_ack1", 32'(bus.ack1), 0);
    check("r0_S",    32'(bus.S),    1450);
    check("r0_cout", 32'(bus.cout), 0);
    bus.req0 = 1'b0;
    tick();
    check("r0_ack0_one_cycle", 32'(bus.ack0), 0);
    check("r0_busy_idle",      32'(bus.busy), 0);

    // req1 alone
    bus.req1 = 1'b1; bus.a1 = 16'd5045; bus.b1 = 16'd45042; bus.cin1 = 1'b0;
    wait_ack(6, idx, cyc);
    check("r1_who",  32'(idx), 1);
    check("r1_lat",  32'(cyc), 2);
    check("r1_S",    32'(bus.S),    50087);
    check("r1_cout", 32'(bus.cout), 0);
    bus.req1 = 1'b0;
    tick();
    check("r1_ack1_one_cycle", 32'(bus.ack1), 0);

    // simultaneous after reset: PRIO_INIT=0 wins first
    do_reset();
    bus.req0 = 1'b1; bus.a0 = 16'd32768; bus.b0 = 16'd32768; bus.cin0 = 1'b0;
    bus.req1 = 1'b1; bus.a1 = 16'd65535; bus.b1 = 16'd65535; bus.cin1 = 1'b1;
    wait_ack(6, idx, cyc);
    check("sim_first_who", 32'(idx), 0);
    check("sim_first_lat", 32'(cyc), 2);
    check("sim_first_S",   32'(bus.S),    0);
    check("sim_first_cout", 32'(bus.cout), 1);
    bus.req0 = 1'b0;
    wait_ack(6, idx, cyc);
    check("sim_second_who",  32'(idx), 1);
    check("sim_second_lat",  32'(cyc), 3);
    check("sim_second_S",    32'(bus.S),    65535);
    check("sim_second_cout", 32'(bus.cout), 1);
    bus.req1 = 1'b0;
    tick();

    // both held: alternate 0,1,0,1 every 3 cycles
    do_reset();
    bus.req0 = 1'b1; bus.a0 = 16'd1;   bus.b0 = 16'd2;   bus.cin0 = 1'b0;
    bus.req1 = 1'b1; bus.a1 = 16'd100; bus.b1 = 16'd200; bus.cin1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_idx = k % 2;
      wait_ack(6, idx, cyc);
      check($sformatf("rr%0d_who", k), 32'(idx), 32'(exp_idx));
      check($sformatf("rr%0d_gap", k), 32'(cyc), (k == 0) ? 2 : 3);
      check($sformatf("rr%0d_S", k),   32'(bus.S), (exp_idx == 0) ? 3 : 301);
    end
    clear_reqs();
    tick();
    tick();

    // reset pulsed during ADD discards the operation
    bus.req0 = 1'b1; bus.a0 = 16'd1000; bus.b0 = 16'd2000; bus.cin0 = 1'b0;
    tick();
    check("rst_mid_busy_before", 32'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_S",    32'(bus.S),    0);
    check("rst_mid_cout", 32'(bus.cout), 0);
    check("rst_mid_busy", 32'(bus.busy), 0);
    check("rst_mid_acks", 32'({bus.ack1, bus.ack0}), 0);
    tick();
    check("rst_hold_ack0", 32'(bus.ack0), 0);
    rst_n = 1'b1;
    wait_ack(6, idx, cyc);
    check("rst_reserve_who", 32'(idx), 0);
    check("rst_reserve_lat", 32'(cyc), 2);
    check("rst_reserve_S",   32'(bus.S), 3000);
    bus.req0 = 1'b0;
    tick();

    // req1 arriving during req0's ADD waits and keeps its own operands
    bus.req0 = 1'b1; bus.a0 = 16'd7; bus.b0 = 16'd8; bus.cin0 = 1'b1;
    tick();
    bus.req1 = 1'b1; bus.a1 = 16'd40000; bus.b1 = 16'd30000; bus.cin1 = 1'b0;
    tick();
    check("late_ack0",  32'(bus.ack0), 1);
    check("late_ack1",  32'(bus.ack1), 0);
    check("late_S0",    32'(bus.S),    16);
    check("late_cout0", 32'(bus.cout), 0);
    bus.req0 = 1'b0;
    wait_ack(6, idx, cyc);
    check("late_who1",  32'(idx), 1);
    check("late_lat1",  32'(cyc), 3);
    check("late_S1",    32'(bus.S),    4464);
    check("late_cout1", 32'(bus.cout), 1);
    bus.req1 = 1'b0;
    tick();
    tick();
    check("final_S_hold", 32'(bus.S), 4464);
    check("final_busy",   32'(bus.busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
